alu_unit: RTL and testbench

Integer execution unit on the consumer side of the reservation-station issue port. Each cycle it accepts at most one issued operation, evaluates it, and queues the tagged result in a small FIFO. The FIFO head is presented on the ALU common-data-bus slot (`alu_valid/alu_value/alu_dependency`) and stays there until the CDB arbiter grants it. `alu_full` throttles the reservation station.

---
 rtl/alu_unit_pkg.sv | 40 ++++
 rtl/alu_result_fifo.sv | 90 +++++++++
 rtl/alu_unit.sv | 57 +++++
 tb/tb_alu_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// Shared constants for the integer ALU: operation-class encoding, ROB tag width
// and the combinational result function used by the execution unit.
package alu_unit_pkg;

  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // The variant bit only matters for ADD/SUB and SRL/SRA.
  function automatic logic [31:0] alu_compute(
    input logic [2:0]  op_l1,
    input logic        op_l2,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op_l1)
      ALU_ADD:  r = op_l2 ? (a - b) : (a + b);
      ALU_SLL:  r = a << sh;
      ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'd0, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = op_l2 ? $unsigned($signed(a) >>> sh) : (a >> sh);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO with registered head outputs: the head entry after each edge is
// precomputed so that a push into an empty queue is visible right after the edge.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_next;
  logic [PW-1:0]    wr_next;
  logic [PW:0]      count_next;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  // Next-state for pointers, count and the head entry.
  always_comb begin
    do_pop     = en && !clear && pop && (count != {(PW+1){1'b0}});
    do_push    = en && !clear && push && ((count != CNT_DEPTH) || do_pop);
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    count_next = count;
    if (en && clear) begin
      rd_next    = {PW{1'b0}};
      wr_next    = {PW{1'b0}};
      count_next = {(PW+1){1'b0}};
    end else begin
      rd_next = do_pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
      wr_next = do_push ? (wr_ptr + PTR_ONE) : wr_ptr;
      case ({do_push, do_pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
    // A same-edge write lands at the new head only when the queue ends with one entry.
    if (do_push && (wr_ptr == rd_next)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // Pointer, count and registered head state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= {PW{1'b0}};
      wr_ptr     <= {PW{1'b0}};
      count      <= {(PW+1){1'b0}};
      head_valid <= 1'b0;
      head_data  <= {WIDTH{1'b0}};
    end else if (en) begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      count      <= count_next;
      head_valid <= (count_next != {(PW+1){1'b0}});
      head_data  <= head_next;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Integer execution unit: evaluates one issued operation per cycle and queues
// the tagged result for the ALU slot of the common data bus.
module alu_unit #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int ROB_SIZE_WIDTH = alu_unit_pkg::ROB_SIZE_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear_in,
  input  logic                      issue_valid,
  input  logic [2:0]                issue_op_L1,
  input  logic                      issue_op_L2,
  input  logic [31:0]               issue_opr1,
  input  logic [31:0]               issue_opr2,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic                      cdb_grant,
  output logic                      alu_valid,
  output logic [31:0]               alu_value,
  output logic [ROB_SIZE_WIDTH-1:0] alu_dependency,
  output logic                      alu_full
);

  import alu_unit_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int EW = 32 + ROB_SIZE_WIDTH;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(QUEUE_DEPTH - 1);

  logic [31:0]   result;
  logic [EW-1:0] head;
  logic [CW-1:0] count;

  assign result = alu_compute(issue_op_L1, issue_op_L2, issue_opr1, issue_opr2);

  alu_result_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .en         (rdy_in),
    .clear      (clear_in),
    .push       (issue_valid),
    .pop        (cdb_grant),
    .push_data  ({result, issue_rob_id}),
    .head_valid (alu_valid),
    .head_data  (head),
    .count      (count)
  );

  assign alu_value      = head[EW-1:ROB_SIZE_WIDTH];
  assign alu_dependency = head[ROB_SIZE_WIDTH-1:0];
  // One slot of slack covers an issue already sitting in the RS output register.
  assign alu_full       = (count >= FULL_LEVEL);

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed scenarios then randomized traffic,
// checked against a queue-based reference model.
module tb_alu_unit;

  localparam int D = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        issue_valid;
  logic [2:0]  issue_op_L1;
  logic        issue_op_L2;
  logic [31:0] issue_opr1;
  logic [31:0] issue_opr2;
  logic [3:0]  issue_rob_id;
  logic        cdb_grant;
  logic        alu_valid;
  logic [31:0] alu_value;
  logic [3:0]  alu_dependency;
  logic        alu_full;

  typedef struct {
    logic [31:0] value;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  alu_unit #(.QUEUE_DEPTH(D), .ROB_SIZE_WIDTH(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear_in       (clear_in),
    .issue_valid    (issue_valid),
    .issue_op_L1    (issue_op_L1),
    .issue_op_L2    (issue_op_L2),
    .issue_opr1     (issue_opr1),
    .issue_opr2     (issue_opr2),
    .issue_rob_id   (issue_rob_id),
    .cdb_grant      (cdb_grant),
    .alu_valid      (alu_valid),
    .alu_value      (alu_value),
    .alu_dependency (alu_dependency),
    .alu_full       (alu_full)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] ref_result(input logic [2:0] l1, input logic l2,
                                             input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b % 32);
    case (l1)
      3'd0:    return l2 ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return (l2 && a[31]) ? ~((~a) >> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies issue/grant/clear to the expected-result queue at each edge.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q.delete();
    end else if (rdy_in) begin
      if (clear_in) begin
        q.delete();
      end else begin
        bit popped;
        popped = cdb_grant && (q.size() > 0);
        if (popped) void'(q.pop_front());
        if (issue_valid) begin
          if (q.size() < D) begin
            exp_t e;
            e.value = ref_result(issue_op_L1, issue_op_L2, issue_opr1, issue_opr2);
            e.tag   = issue_rob_id;
            q.push_back(e);
          end else begin
            $display("note: protocol violation, push into a full queue dropped at %0t", $time);
          end
        end
      end
    end
  end

  // Monitor: compare the presented CDB slot against the scoreboard head.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      cmp("valid", 32'(alu_valid), 32'(q.size() != 0));
      cmp("full", 32'(alu_full), 32'(q.size() >= D - 1));
      if (q.size() != 0) begin
        cmp("value", alu_value, q[0].value);
        cmp("tag", 32'(alu_dependency), 32'(q[0].tag));
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic v, input logic [2:0] l1, input logic l2,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    issue_valid  = v;
    issue_op_L1  = l1;
    issue_op_L2  = l2;
    issue_opr1   = a;
    issue_opr2   = b;
    issue_rob_id = tag;
  endtask

  logic [2:0]  vl1 [8] = '{3'd0, 3'd5, 3'd5, 3'd2, 3'd3, 3'd1, 3'd4, 3'd7};
  logic        vl2 [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] va  [8] = '{32'h0, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'h1, 32'hF0F0F0F0, 32'h12345678};
  logic [31:0] vb  [8] = '{32'h1, 32'h4, 32'h4, 32'h1, 32'h1, 32'h21, 32'hFF00FF00, 32'h0000FFFF};
  logic [31:0] vr  [8] = '{32'hFFFFFFFF, 32'hF8000000, 32'h08000000, 32'h1,
                           32'h0, 32'h2, 32'h0FF00FF0, 32'h00005678};

  initial begin
    logic        hv;
    logic [31:0] hval;
    logic [3:0]  htag;
    logic        hfull;
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    clear_in  = 1'b0;
    cdb_grant = 1'b0;
    issue(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    #2;
    cmp("reset_valid", 32'(alu_valid), 32'd0);
    cmp("reset_value", alu_value, 32'd0);
    cmp("reset_tag", 32'(alu_dependency), 32'd0);
    cmp("reset_full", 32'(alu_full), 32'd0);
    repeat (2) step();
    rst_in = 1'b0;

    // ADD with immediate grant: one cycle on the bus, then empty.
    issue(1'b1, 3'd0, 1'b0, 32'd5, 32'd7, 4'd3);
    cdb_grant = 1'b1;
    step();
    issue_valid = 1'b0;
    cmp("add_valid", 32'(alu_valid), 32'd1);
    cmp("add_value", alu_value, 32'd12);
    cmp("add_tag", 32'(alu_dependency), 32'd3);
    step();
    cmp("add_drained", 32'(alu_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(1'b1, vl1[i], vl2[i], va[i], vb[i], 4'(i));
      step();
      issue_valid = 1'b0;
      cmp($sformatf("op%0d_value", i), alu_value, vr[i]);
      step();
    end

    // Fill to full with grant held low, then overfill and push-with-pop at count 4.
    cdb_grant = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      issue(1'b1, 3'd0, 1'b0, 32'(t * 100), 32'd1, 4'(t));
      step();
      cmp($sformatf("fill%0d_full", t), 32'(alu_full), 32'(t >= 3));
      cmp($sformatf("fill%0d_head", t), 32'(alu_dependency), 32'd1);
    end
    issue(1'b1, 3'd6, 1'b0, 32'hAA, 32'h55, 4'd12);
    step();
    cmp("drop_head", 32'(alu_dependency), 32'd1);
    issue(1'b1, 3'd4, 1'b0, 32'h9, 32'h0, 4'd9);
    cdb_grant = 1'b1;
    step();
    issue_valid = 1'b0;
    cmp("pushpop_head", 32'(alu_dependency), 32'd2);
    cmp("pushpop_full", 32'(alu_full), 32'd1);
    for (int t = 0; t < 3; t++) begin
      step();
      cmp($sformatf("drain%0d_tag", t), 32'(alu_dependency), (t == 2) ? 32'd9 : 32'(t + 3));
    end
    step();
    cmp("drain_empty", 32'(alu_valid), 32'd0);

    // Flush with a same-cycle issue.
    cdb_grant = 1'b0;
    issue(1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 4'd5);
    step();
    issue(1'b1, 3'd0, 1'b0, 32'd2, 32'd2, 4'd6);
    step();
    issue(1'b1, 3'd0, 1'b0, 32'd3, 32'd3, 4'd7);
    clear_in = 1'b1;
    step();
    clear_in    = 1'b0;
    issue_valid = 1'b0;
    cmp("clear_valid", 32'(alu_valid), 32'd0);
    cdb_grant = 1'b1;
    repeat (2) step();
    cmp("clear_stays_empty", 32'(alu_valid), 32'd0);

    // Freeze with rdy_in low, then asynchronous reset mid-cycle.
    cdb_grant = 1'b0;
    issue(1'b1, 3'd6, 1'b0, 32'h10, 32'h01, 4'd10);
    step();
    issue(1'b1, 3'd6, 1'b0, 32'h20, 32'h02, 4'd11);
    step();
    hv = alu_valid; hval = alu_value; htag = alu_dependency; hfull = alu_full;
    rdy_in = 1'b0;
    for (int t = 0; t < 3; t++) begin
      issue_valid = ~issue_valid;
      cdb_grant   = ~cdb_grant;
      clear_in    = (t == 1);
      step();
      cmp("frz_valid", 32'(alu_valid), 32'(hv));
      cmp("frz_value", alu_value, hval);
      cmp("frz_tag", 32'(alu_dependency), 32'(htag));
      cmp("frz_full", 32'(alu_full), 32'(hfull));
    end
    rdy_in      = 1'b1;
    clear_in    = 1'b0;
    cdb_grant   = 1'b0;
    issue(1'b1, 3'd6, 1'b0, 32'h30, 32'h03, 4'd13);
    step();
    #2;
    rst_in      = 1'b1;
    issue_valid = 1'b0;
    #1;
    cmp("arst_valid", 32'(alu_valid), 32'd0);
    cmp("arst_value", alu_value, 32'd0);
    cmp("arst_tag", 32'(alu_dependency), 32'd0);
    cmp("arst_full", 32'(alu_full), 32'd0);
    step();
    rst_in = 1'b0;

    // Randomized traffic honouring the full back-pressure.
    for (int n = 0; n < 1500; n++) begin
      rdy_in    = ($urandom_range(9, 0) != 0);
      clear_in  = ($urandom_range(39, 0) == 0);
      cdb_grant = ($urandom_range(9, 0) < 6);
      issue(($urandom_range(3, 0) != 0) && (q.size() < D),
            3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
            $urandom(), ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom(),
            4'($urandom_range(15, 0)));
      step();
    end
    issue_valid = 1'b0;
    clear_in    = 1'b0;
    rdy_in      = 1'b1;
    cdb_grant   = 1'b1;
    repeat (6) step();
    cmp("final_empty", 32'(alu_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
